inst_prefetch_buffer: RTL and testbench

INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

---
 rtl/inst_prefetch_buffer.sv | 145 ++++++++++++++
 tb/tb_inst_prefetch_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_buffer.sv
// Purpose: small in-order instruction prefetch FIFO between the pipeline PC and an instruction memory.
// Latency: a request issues the edge after it is needed; ack data is visible one edge later (no bypass).
// Backpressure: a pipeline stall stops pops; no request issues while the buffer plus the outstanding slot is full.
module inst_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_pc,
    input  logic        cpu_advance,
    output logic [31:0] cpu_inst,
    output logic        cpu_inst_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Pointer width covers DEPTH entries; count needs one extra value for "full".
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Storage and bookkeeping. Entry at rd_ptr always holds the word at exp_pc,
    // and each following entry holds the next sequential word.
    logic [31:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      exp_pc;
    logic [31:0]      fetch_addr;
    logic             discard;

    // Per-cycle decisions.
    logic             hit;
    logic             redirect;
    logic             pop;
    logic             ack;
    logic             push;
    logic             outstanding;
    logic             issue;
    logic [CNT_W-1:0] count_nxt;
    logic [31:0]      fetch_addr_nxt;

    // A hit needs a non-empty buffer whose head address matches the pipeline PC.
    assign hit      = (count != '0) && (cpu_pc == exp_pc);
    // Any PC mismatch is a redirect, even on an empty buffer; the old stream is abandoned.
    assign redirect = (cpu_pc != exp_pc);
    assign pop      = hit && cpu_advance;
    // mem_ack is ignored unless a request is actually pending (e.g. a stale ack after reset).
    assign ack      = mem_req && mem_ack;
    // Ack data is kept only if it belongs to the current stream.
    assign push     = ack && !discard && !redirect;
    // A request that does not complete this cycle stays in flight and blocks a new one.
    assign outstanding    = mem_req && !mem_ack;
    assign fetch_addr_nxt = redirect ? cpu_pc : fetch_addr;

    // Occupancy after this edge's redirect / push / pop.
    always_comb begin
        count_nxt = count;
        if (redirect) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // A new request only goes out when none remains in flight and its slot is free,
    // so count plus the outstanding request never exceeds DEPTH.
    assign issue = !outstanding && (count_nxt < DEPTH_C);

    // Instruction output is NOP unless the head entry is the one the pipeline wants.
    assign cpu_inst_valid = hit;
    assign cpu_inst       = hit ? fifo_mem[rd_ptr] : 32'h0;

    // Data array write; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    // Buffer pointers, occupancy and expected head address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            exp_pc <= RESET_PC;
        end else begin
            count <= count_nxt;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                exp_pc <= cpu_pc;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    exp_pc <= exp_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Discard tracking: a redirect with a request still in flight marks that
    // request's data as stale; the flag clears when its ack arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            discard <= 1'b0;
        end else if (ack) begin
            discard <= 1'b0;
        end else if (redirect && mem_req) begin
            discard <= 1'b1;
        end
    end

    // Memory request port and next-fetch address. mem_addr is held while a
    // request is in flight even across a redirect; the new stream issues at
    // the ack edge of the stale request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0;
            fetch_addr <= RESET_PC;
        end else begin
            if (issue) begin
                mem_req    <= 1'b1;
                mem_addr   <= fetch_addr_nxt;
                fetch_addr <= fetch_addr_nxt + 32'd4;
            end else begin
                fetch_addr <= fetch_addr_nxt;
                if (ack) begin
                    mem_req <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Bench for inst_prefetch_buffer: randomized pipeline/memory behaviour checked
// against a queue-based model of the prefetch rules, plus directed reset cases.
module tb_inst_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XOR_K    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_pc = RESET_PC;
    logic        cpu_advance = 1'b0;
    logic [31:0] cpu_inst;
    logic        cpu_inst_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_pc         (cpu_pc),
        .cpu_advance    (cpu_advance),
        .cpu_inst       (cpu_inst),
        .cpu_inst_valid (cpu_inst_valid),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the buffer is a queue of words for exp_pc, exp_pc+4, ...
    logic [31:0] mq[$];
    logic [31:0] m_exp;
    logic [31:0] m_fetch;
    logic [31:0] m_addr;
    bit          m_req;
    bit          m_disc;

    task automatic model_reset();
        mq.delete();
        m_exp   = RESET_PC;
        m_fetch = RESET_PC;
        m_addr  = 32'h0;
        m_req   = 1'b0;
        m_disc  = 1'b0;
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (mq.size() != 0) && (cpu_pc == m_exp);
        check_eq("inst_valid", 32'(cpu_inst_valid), 32'(ev));
        check_eq("inst", cpu_inst, ev ? mq[0] : 32'h0);
        check_eq("mem_req", 32'(mem_req), 32'(m_req));
        check_eq("mem_addr", mem_addr, m_addr);
        // Independent property: any delivered instruction is the memory word at cpu_pc.
        if (cpu_inst_valid) check_eq("inst_vs_pc", cpu_inst, cpu_pc ^ XOR_K);
    endtask

    // Apply one clock edge to the model using the inputs currently presented.
    task automatic model_step(input bit ack_in, input logic [31:0] rd);
        bit hit, redir, pop, acked, keep;
        hit   = (mq.size() != 0) && (cpu_pc == m_exp);
        redir = (cpu_pc != m_exp);
        pop   = hit && cpu_advance;
        acked = m_req && ack_in;
        keep  = acked && !m_disc && !redir;
        if (redir) begin
            mq.delete();
            m_exp   = cpu_pc;
            m_fetch = cpu_pc;
        end else if (pop) begin
            void'(mq.pop_front());
            m_exp = m_exp + 32'd4;
        end
        if (keep) mq.push_back(rd);
        if (acked) m_disc = 1'b0;
        else if (redir && m_req) m_disc = 1'b1;
        if ((!m_req || acked) && mq.size() < DEPTH) begin
            m_req   = 1'b1;
            m_addr  = m_fetch;
            m_fetch = m_fetch + 32'd4;
        end else if (acked) begin
            m_req = 1'b0;
        end
    endtask

    function automatic logic [31:0] jump_target();
        logic [31:0] t;
        case ($urandom_range(3))
            0:       t = $urandom() & 32'hFFFF_FFFC;
            1:       t = 32'hFFFF_FFF0;
            2:       t = 32'($urandom_range(255)) << 2;
            default: t = cpu_pc + 32'd8;
        endcase
        return t;
    endfunction

    // One cycle per iteration: present inputs, check, advance model, take edge.
    task automatic run_cycles(input int n, input int adv_pct, input int ack_pct, input int jmp_pct);
        for (int i = 0; i < n; i++) begin
            bit          ack, hit;
            logic [31:0] pc_n;
            cpu_advance = ($urandom_range(99) < adv_pct);
            ack         = m_req && ($urandom_range(99) < ack_pct);
            mem_ack     = ack;
            mem_rdata   = ack ? (m_addr ^ XOR_K) : $urandom();
            #1;
            check_outputs();
            hit = (mq.size() != 0) && (cpu_pc == m_exp);
            model_step(ack, mem_rdata);
            if ($urandom_range(99) < jmp_pct) pc_n = jump_target();
            else if (hit && cpu_advance)      pc_n = cpu_pc + 32'd4;
            else                              pc_n = cpu_pc;
            @(posedge clk);
            #1;
            cpu_pc = pc_n;
        end
    endtask

    initial begin
        int waited;
        model_reset();
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Streaming with immediate acks: first request at 0x0, sequential delivery.
        run_cycles(30, 100, 100, 0);
        // Stall with immediate acks: buffer fills and requests stop.
        run_cycles(12, 0, 100, 0);
        check_eq("full_no_req", 32'(mem_req), 32'h0);
        // Redirect of a full buffer.
        cpu_pc = 32'h100;
        run_cycles(8, 50, 100, 0);
        // Mixed random traffic, then slow acks with frequent redirects.
        run_cycles(1500, 70, 40, 3);
        run_cycles(400, 60, 25, 8);

        // Asynchronous reset while a request is pending.
        waited = 0;
        while (!m_req && waited < 50) begin
            run_cycles(1, 50, 0, 0);
            waited++;
        end
        check_eq("req_pending_before_rst", 32'(mem_req), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_req", 32'(mem_req), 32'h0);
        check_eq("async_rst_valid", 32'(cpu_inst_valid), 32'h0);
        model_reset();
        cpu_pc = RESET_PC;
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Stale ack right after release must be ignored.
        mem_ack     = 1'b1;
        mem_rdata   = 32'hDEAD_BEEF;
        cpu_advance = 1'b1;
        #1;
        check_outputs();
        model_step(1'b1, mem_rdata);
        @(posedge clk);
        #1;
        check_eq("post_rst_addr", mem_addr, RESET_PC);
        run_cycles(40, 80, 60, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
